// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: free-running h/v counters, sync decode, and a
// pixel request stream that runs one cycle ahead of the visible rgb window.
module vga_timing_ctrl #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_VALID  = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_VALID  = 480,
  parameter int V_FRONT  = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [15:0] pic_data,
  output logic [9:0]  pic_x,
  output logic [9:0]  pic_y,
  output logic        pix_req,
  output logic        rgb_valid,
  output logic [15:0] rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [9:0] H_LAST    = 10'(H_SYNC + H_BACK + H_VALID + H_FRONT - 1);
  localparam logic [9:0] V_LAST    = 10'(V_SYNC + V_BACK + V_VALID + V_FRONT - 1);
  localparam logic [9:0] HS_END    = 10'(H_SYNC);
  localparam logic [9:0] VS_END    = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_BEG = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_END = 10'(H_SYNC + H_BACK + H_VALID);
  localparam logic [9:0] H_REQ_BEG = 10'(H_SYNC + H_BACK - 1);
  localparam logic [9:0] H_REQ_END = 10'(H_SYNC + H_BACK + H_VALID - 1);
  localparam logic [9:0] V_ACT_BEG = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_END = 10'(V_SYNC + V_BACK + V_VALID);

  logic [9:0] cnt_h;
  logic [9:0] cnt_v;
  logic       line_end;
  logic       frame_end;
  logic       v_act;

  assign line_end  = (cnt_h == H_LAST);
  assign frame_end = line_end && (cnt_v == V_LAST);

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      cnt_h     <= '0;
      cnt_v     <= '0;
      frame_cnt <= '0;
    end else begin
      cnt_h <= line_end ? '0 : cnt_h + 10'd1;
      if (line_end) begin
        cnt_v <= (cnt_v == V_LAST) ? '0 : cnt_v + 10'd1;
      end
      if (frame_end) begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  // Everything below is a pure decode of the registered counters, so an
  // asynchronous reset drives every output to its idle value at once.
  assign v_act     = (cnt_v >= V_ACT_BEG) && (cnt_v < V_ACT_END);
  assign pix_req   = v_act && (cnt_h >= H_REQ_BEG) && (cnt_h < H_REQ_END);
  assign rgb_valid = v_act && (cnt_h >= H_ACT_BEG) && (cnt_h < H_ACT_END);

  assign pic_x = pix_req ? (cnt_h - H_REQ_BEG) : 10'h3FF;
  assign pic_y = pix_req ? (cnt_v - V_ACT_BEG) : 10'h3FF;

  // The pixel source registers its own output, so pic_data is already
  // aligned to the display cycle that follows each request.
  assign rgb = rgb_valid ? pic_data : 16'h0000;

  assign hsync       = (cnt_h < HS_END) ? SYNC_POL : ~SYNC_POL;
  assign vsync       = (cnt_v < VS_END) ? SYNC_POL : ~SYNC_POL;
  assign frame_start = (cnt_h == 10'd0) && (cnt_v == 10'd0);

endmodule

// File: doc/vga_timing_ctrl.md
# vga_timing_ctrl

Raster timing generator and pixel-data consumer for the VGA path. Runs 640x480@60 Hz counters on `vga_clk` (25.175/25 MHz) and issues pixel-coordinate requests (`pic_x`, `pic_y`) one cycle ahead of the active window to a pixel generator whose `pic_data` is registered. It returns that data on `rgb` aligned with `hsync`/`vsync`. It sits between any picture source (colour bars, character ROM, sprite layer) and the board DAC pins.

## Interface
- `H_SYNC`, 96, hsync pulse width (clocks)
- `H_BACK`, 48, horizontal back porch
- `H_VALID`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BACK`, 33, vertical back porch
- `V_VALID`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `SYNC_POL`, 0, sync level while in the pulse (0 = active-low)

Ports:
- `vga_clk`  in  1  pixel clock; all logic on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `pic_data`  in  16  RGB565 from the pixel source, valid 1 cycle after the request
- `pic_x`  out  10  requested column 0..H_VALID-1; 10'h3FF when no request
- `pic_y`  out  10  requested row 0..V_VALID-1; 10'h3FF when no request
- `pix_req`  out  1  coordinate request strobe
- `rgb_valid`  out  1  high during the active display window
- `rgb`  out  16  pixel to DAC; 16'h0000 outside the active window
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `frame_start`  out  1  1-cycle pulse at cnt_h==0 && cnt_v==0
- `frame_cnt`  out  16  completed-frame counter, wraps

## Operation
- Derived constants:
  - H_TOTAL = sum of the H_* timing parameters (800).
  - V_TOTAL = sum of the V_* timing parameters (525).
  - HA = H_SYNC+H_BACK (144).
  - VA = V_SYNC+V_BACK (35).
- `cnt_h` (10 bit) counts 0..H_TOTAL-1 and wraps to 0.
- `cnt_v` (10 bit) increments when `cnt_h`==H_TOTAL-1. It wraps to 0 when it is also at V_TOTAL-1.
- `hsync` = SYNC_POL when `cnt_h` < H_SYNC, else ~SYNC_POL. `vsync` uses the same rule on `cnt_v` < V_SYNC. Both are decoded from the registered counters only.
- v_act = (`cnt_v` >= VA) && (`cnt_v` < VA+V_VALID).
- `pix_req` = v_act && (`cnt_h` >= HA-1) && (`cnt_h` < HA+H_VALID-1).
- While `pix_req` is high:
  - `pic_x` = `cnt_h` - (HA-1).
  - `pic_y` = `cnt_v` - VA.
  - Both are 10-bit unsigned and never exceed 639/479.
- `rgb_valid` = v_act && (`cnt_h` >= HA) && (`cnt_h` < HA+H_VALID).
- `rgb` = `rgb_valid` ? `pic_data` : 0. The block does not register `pic_data`, because the source already does.
- `frame_cnt` increments on the cycle where `cnt_h`==H_TOTAL-1 && `cnt_v`==V_TOTAL-1. 16'hFFFF wraps to 0.
- No sync state machine is needed beyond the two counters. The phase (sync/back/active/front) is a pure decode of the counters.

## Timing
- Reset values while `rst`=1:
  - `cnt_h`=0, `cnt_v`=0, `frame_cnt`=0.
  - `hsync`=`vsync`=SYNC_POL (pulse region).
  - `pix_req`=0, `rgb_valid`=0, `rgb`=0.
  - `pic_x`=`pic_y`=10'h3FF.
  - `frame_start`=1, since its decode is true at the counter origin.
- First clock edge after `rst` falls: `cnt_h` becomes 1. The counters are free-running from then on.
- Request-to-display latency is exactly 1 cycle:
  - `pic_x`=N is presented at `cnt_h`=HA-1+N.
  - `rgb` shows that pixel at `cnt_h`=HA+N.
  - Default values: request at `cnt_h`=143..782, display at 144..783.
- Line = 800 clocks. Frame = 420000 clocks. `hsync` low 96 clocks per line. `vsync` low 2 lines (1600 clocks) per frame.
- `pix_req` never asserts on lines outside v_act, including the cycle before line VA starts.
- Reset asserted mid-frame:
  - All outputs take their reset values asynchronously, with no wait for a clock edge.
  - After release, timing restarts from the frame origin. No partial line is emitted.
- Simultaneous line wrap and frame wrap on the same cycle: `cnt_v`→0, `cnt_h`→0 and `frame_cnt`+1 all occur on one edge.

## Test plan
- Reset then release: all reset values are observed while `rst` is high. After 800 clocks, `cnt_v`=1 and `hsync` has been low for exactly 96 clocks.
- Request alignment:
  - Drive `pic_data` = {6'b0, `pic_x`} delayed one register.
  - On line 35, `pix_req` rises at `cnt_h`=143 with `pic_x`=0.
  - `rgb_valid` rises at 144 with `rgb`=16'h0000, and `rgb` at `cnt_h`=783 is 16'h027F.
  - `rgb_valid` falls at 784.
- Vertical window:
  - `pix_req` stays 0 on lines 0..34 and 515..524.
  - `pic_y`=0 on line 35 and `pic_y`=479 on line 514.
  - `vsync` is low for lines 0..1 only.
- Frame wrap: after 420000 clocks, `frame_start` pulses and `frame_cnt`=1. With `frame_cnt` preloaded by forcing to 16'hFFFF, one more frame gives 0.
- Mid-frame reset: assert `rst` at line 200, `cnt_h`=400 for 3 cycles. Outputs zero immediately, and the restart matches the first scenario bit-exactly.
- SYNC_POL=1 instance: `hsync`/`vsync` are high during the pulse and low elsewhere, with otherwise identical timing.
